// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared sizing helpers for the MAC multiply front-end.
//   csa_levels(rows)     : Wallace levels needed to reduce `rows` rows to two
//   rows_after(rows,lvl) : rows remaining after `lvl` Wallace levels
//   mul_latency(n,k)     : cycles from input accept to product valid
// No ports (package).
// -----------------------------------------------------------------------------
package mac_pkg;

  // One Wallace level compresses every full group of three rows into two
  // and passes the zero, one or two leftover rows through untouched.
  function automatic int rows_after(input int rows, input int lvl);
    int r;
    r = rows;
    for (int i = 0; i < lvl; i++) begin
      if (r > 2) r = 2 * (r / 3) + (r % 3);
    end
    return r;
  endfunction

  function automatic int csa_levels(input int rows);
    int r;
    int n;
    r = rows;
    n = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      n++;
    end
    return n;
  endfunction

  // Input reg + partial-product reg + one reg per group of k tree levels
  // (last group may be short) + final CPA reg. The tree always sees n+1
  // rows, so the result does not depend on the signed/unsigned mode.
  function automatic int mul_latency(input int n, input int k);
    return 3 + (csa_levels(n + 1) + k - 1) / k;
  endfunction

endpackage

// File: rtl/mac_csa.sv
// -----------------------------------------------------------------------------
// mac_csa
// W-bit 3:2 carry-save adder. The carry vector is pre-shifted by one place,
// so the carry out of bit W-1 is discarded.
//   x, y, z : input rows
//   s       : sum row
//   c       : carry row, already shifted to its weight
// -----------------------------------------------------------------------------
module mac_csa #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};

endmodule

// File: rtl/mac_csa_level.sv
// -----------------------------------------------------------------------------
// mac_csa_level
// One combinational Wallace level. It takes M rows of W bits and produces
// rows_after(M,1) rows. Rows are packed LSB-first, with row r at [r*W +: W].
//   rows_in  : M packed input rows
//   rows_out : compressed rows. Each CSA group gives a sum row and a carry
//              row, and leftover rows follow at the top.
// -----------------------------------------------------------------------------
module mac_csa_level
  import mac_pkg::*;
#(
  parameter  int M  = 3,
  parameter  int W  = 8,
  localparam int MO = rows_after(M, 1)
) (
  input  logic [M*W-1:0]  rows_in,
  output logic [MO*W-1:0] rows_out
);

  localparam int G = M / 3;
  localparam int R = M - 3 * G;

  for (genvar g = 0; g < G; g++) begin : g_csa
    mac_csa #(.W(W)) u_csa (
      .x (rows_in[(3*g)*W +: W]),
      .y (rows_in[(3*g+1)*W +: W]),
      .z (rows_in[(3*g+2)*W +: W]),
      .s (rows_out[(2*g)*W +: W]),
      .c (rows_out[(2*g+1)*W +: W])
    );
  end

  for (genvar r = 0; r < R; r++) begin : g_pass
    assign rows_out[(2*G+r)*W +: W] = rows_in[(3*G+r)*W +: W];
  end

endmodule

// File: rtl/mac_mul_pipe.sv
// -----------------------------------------------------------------------------
// mac_mul_pipe
// Pipelined Wallace-tree multiplier. Each transaction selects signed or
// unsigned mode and carries a pass-through tag. Flow control is valid/ready.
// Pipeline order: input reg, partial-product reg, a tree reg after every
// CSA_PER_STAGE levels (and after the last level), then the CPA/output reg.
//   i_clk, i_rst_n          : clock; asynchronous active-low reset
//   i_flush                 : synchronous clear of every valid bit
//   i_mul_a, i_mul_b        : operands, INPUT_WIDTH bits each
//   i_mul_signed            : 1 = two's complement operands, 0 = unsigned
//   i_mul_tag, i_mul_valid  : tag and valid for the input transaction
//   o_mul_ready             : input accepted when i_mul_valid && o_mul_ready
//   o_mul_val, o_mul_tag    : product (2*INPUT_WIDTH bits) and its tag
//   o_mul_valid, i_mul_ready: output handshake
// o_mul_ready is a combinational function of i_mul_ready. A stall holds every
// stage at once, so bubbles stay in the pipeline.
// -----------------------------------------------------------------------------
module mac_mul_pipe
  import mac_pkg::*;
#(
  parameter  int INPUT_WIDTH   = 16,
  parameter  int CSA_PER_STAGE = 2,
  parameter  int TAG_WIDTH     = 4,
  localparam int OUTPUT_WIDTH  = 2 * INPUT_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic [INPUT_WIDTH-1:0]  i_mul_a,
  input  logic [INPUT_WIDTH-1:0]  i_mul_b,
  input  logic                    i_mul_signed,
  input  logic [TAG_WIDTH-1:0]    i_mul_tag,
  input  logic                    i_mul_valid,
  output logic                    o_mul_ready,
  output logic [OUTPUT_WIDTH-1:0] o_mul_val,
  output logic [TAG_WIDTH-1:0]    o_mul_tag,
  output logic                    o_mul_valid,
  input  logic                    i_mul_ready
);

  localparam int N      = INPUT_WIDTH;
  localparam int W      = OUTPUT_WIDTH;
  localparam int ROWS   = N + 1;
  localparam int LEVELS = csa_levels(ROWS);
  localparam int LAT    = mul_latency(N, CSA_PER_STAGE);

  // Baugh-Wooley correction row: 2^N + 2^(2N-1), taken modulo 2^(2N).
  localparam logic [W-1:0] BW_CONST = {1'b1, {(N-2){1'b0}}, 1'b1, {N{1'b0}}};

  logic                   stall;
  logic [N-1:0]           a_q;
  logic [N-1:0]           b_q;
  logic                   sgn_q;
  logic [ROWS*W-1:0]      pp_d;
  logic [ROWS*W-1:0]      pp_q;
  logic [W-1:0]           row;
  logic [W-1:0]           cpa_sum;
  logic [W-1:0]           out_q;
  logic [LAT-1:0]         vld_q;
  logic [TAG_WIDTH-1:0]   tag_q [LAT];

  assign stall       = vld_q[LAT-1] & ~i_mul_ready;
  assign o_mul_ready = ~stall;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in a stage samples the values from before the clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
    end else if (!stall) begin
      a_q   <= i_mul_a;
      b_q   <= i_mul_b;
      sgn_q <= i_mul_signed;
    end
  end

  // Partial products. In signed mode, a term invert that touches exactly one
  // sign bit (i or j equal to N-1) is inverted, and the correction row then
  // restores the value.
  // NOTE: every variable gets a default at the top of the block, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pp_d = '0;
    row  = '0;
    for (int i = 0; i < N; i++) begin
      row = '0;
      for (int j = 0; j < N; j++) begin
        row[j] = (a_q[j] & b_q[i]) ^ (sgn_q & ((i == N-1) != (j == N-1)));
      end
      pp_d[i*W +: W] = row << i;
    end
    if (sgn_q) pp_d[N*W +: W] = BW_CONST;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    pp_q <= '0;
    else if (!stall) pp_q <= pp_d;
  end

  // Wallace tree. A level is registered after every CSA_PER_STAGE levels,
  // and the last level is always registered.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int MI = rows_after(ROWS, l - 1);
    localparam int MO = rows_after(ROWS, l);
    logic [MI*W-1:0] rows_i;
    logic [MO*W-1:0] rows_c;
    logic [MO*W-1:0] rows_o;

    if (l == 1) begin : g_src_pp
      assign rows_i = pp_q;
    end else begin : g_src_lvl
      assign rows_i = g_lvl[l-1].rows_o;
    end

    mac_csa_level #(.M(MI), .W(W)) u_level (
      .rows_in  (rows_i),
      .rows_out (rows_c)
    );

    if ((l % CSA_PER_STAGE == 0) || (l == LEVELS)) begin : g_reg
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    rows_o <= '0;
        else if (!stall) rows_o <= rows_c;
      end
    end else begin : g_wire
      assign rows_o = rows_c;
    end
  end

  assign cpa_sum = g_lvl[LEVELS].rows_o[W-1:0] + g_lvl[LEVELS].rows_o[2*W-1:W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    out_q <= '0;
    else if (!stall) out_q <= cpa_sum;
  end

  // Valid and tag shift alongside the data stages. A flush clears only the
  // valid bits and takes priority over an input accepted in the same cycle.
  // NOTE: the tag array is small and is reset element by element, so the
  // reset value of o_mul_tag is defined.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      if (i_flush)     vld_q <= '0;
      else if (!stall) vld_q <= {vld_q[LAT-2:0], i_mul_valid};
      if (!stall) begin
        tag_q[0] <= i_mul_tag;
        for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign o_mul_val   = out_q;
  assign o_mul_tag   = tag_q[LAT-1];
  assign o_mul_valid = vld_q[LAT-1];

endmodule

// File: tb/tb_mac_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_mac_mul_pipe
// Drives three configurations in lock-step: N=16/K=2 (directed cases), N=8/K=1
// and N=32/K=3 (random operands). Each configuration has a model made of a
// delay line with a fixed number of slots. Latencies come from the rules:
// 6, 7 and 6. Products come from plain signed or unsigned arithmetic.
// -----------------------------------------------------------------------------
module tb_mac_mul_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_mul_signed;
  logic [3:0]  i_mul_tag;
  logic        i_mul_valid;
  logic        i_mul_ready;
  logic [31:0] a_r [3];
  logic [31:0] b_r [3];

  logic        ordy [3];
  logic        ov   [3];
  logic [3:0]  otag [3];
  logic [31:0] val16;
  logic [15:0] val8;
  logic [63:0] val32;

  int nerr = 0;
  int nchk = 0;
  int lat [3] = '{6, 7, 6};
  int wid [3] = '{16, 8, 32};

  logic        mv [3][8];
  logic [63:0] mp [3][8];
  logic [3:0]  mt [3][8];

  always #5 i_clk = ~i_clk;

  mac_mul_pipe #(.INPUT_WIDTH(16), .CSA_PER_STAGE(2), .TAG_WIDTH(4)) u_dut16 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_mul_a(a_r[0][15:0]), .i_mul_b(b_r[0][15:0]), .i_mul_signed(i_mul_signed),
    .i_mul_tag(i_mul_tag), .i_mul_valid(i_mul_valid), .o_mul_ready(ordy[0]),
    .o_mul_val(val16), .o_mul_tag(otag[0]), .o_mul_valid(ov[0]), .i_mul_ready(i_mul_ready)
  );

  mac_mul_pipe #(.INPUT_WIDTH(8), .CSA_PER_STAGE(1), .TAG_WIDTH(4)) u_dut8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_mul_a(a_r[1][7:0]), .i_mul_b(b_r[1][7:0]), .i_mul_signed(i_mul_signed),
    .i_mul_tag(i_mul_tag), .i_mul_valid(i_mul_valid), .o_mul_ready(ordy[1]),
    .o_mul_val(val8), .o_mul_tag(otag[1]), .o_mul_valid(ov[1]), .i_mul_ready(i_mul_ready)
  );

  mac_mul_pipe #(.INPUT_WIDTH(32), .CSA_PER_STAGE(3), .TAG_WIDTH(4)) u_dut32 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_mul_a(a_r[2]), .i_mul_b(b_r[2]), .i_mul_signed(i_mul_signed),
    .i_mul_tag(i_mul_tag), .i_mul_valid(i_mul_valid), .o_mul_ready(ordy[2]),
    .o_mul_val(val32), .o_mul_tag(otag[2]), .o_mul_valid(ov[2]), .i_mul_ready(i_mul_ready)
  );

  // Exact n-bit product, reduced to 2n bits.
  function automatic logic [63:0] ref_mul(input int n, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    logic [63:0]        msk;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    msk = (n >= 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    sa  = $signed({32'd0, a} & msk);
    sb  = $signed({32'd0, b} & msk);
    if (s && a[n-1]) sa = sa - $signed(64'd1 << n);
    if (s && b[n-1]) sb = sb - $signed(64'd1 << n);
    p = sa * sb;
    if (n >= 32) return $unsigned(p);
    return $unsigned(p) & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  function automatic logic [63:0] act_val(input int d);
    if (d == 0) return {32'd0, val16};
    if (d == 1) return {48'd0, val8};
    return val32;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 8; k++) mv[d][k] = 1'b0;
  endtask

  // Set up the next cycle's inputs. The two sweep configurations always get
  // fresh random operands.
  task automatic drive(input logic v, input logic [31:0] a16, input logic [31:0] b16,
                       input logic s, input logic [3:0] t);
    i_mul_valid  = v;
    a_r[0]       = a16;
    b_r[0]       = b16;
    a_r[1]       = $urandom;
    b_r[1]       = $urandom;
    a_r[2]       = $urandom;
    b_r[2]       = $urandom;
    i_mul_signed = s;
    i_mul_tag    = t;
  endtask

  // One clock cycle. Called at a negedge after the inputs are set. Checks the
  // outputs, advances the model at the posedge, and returns at the next negedge.
  task automatic cyc();
    logic stl [3];
    logic ev;
    #1;
    if (!i_rst_n) model_clear();
    for (int d = 0; d < 3; d++) begin
      ev     = mv[d][lat[d]-1];
      stl[d] = ev && !i_mul_ready;
      check($sformatf("valid_n%0d", wid[d]), 64'(ov[d]), 64'(ev));
      check($sformatf("ready_n%0d", wid[d]), 64'(ordy[d]), 64'(!stl[d]));
      if (ev) begin
        check($sformatf("product_n%0d", wid[d]), act_val(d), mp[d][lat[d]-1]);
        check($sformatf("tag_n%0d", wid[d]), 64'(otag[d]), 64'(mt[d][lat[d]-1]));
      end
      if (!i_rst_n) begin
        check($sformatf("reset_val_n%0d", wid[d]), act_val(d), 64'd0);
        check($sformatf("reset_tag_n%0d", wid[d]), 64'(otag[d]), 64'd0);
      end
    end
    @(posedge i_clk);
    for (int d = 0; d < 3; d++) begin
      if (!i_rst_n) begin
        for (int k = 0; k < 8; k++) mv[d][k] = 1'b0;
      end else if (i_flush) begin
        for (int k = 0; k < 8; k++) mv[d][k] = 1'b0;
      end else if (!stl[d]) begin
        for (int k = lat[d] - 1; k > 0; k--) begin
          mv[d][k] = mv[d][k-1];
          mp[d][k] = mp[d][k-1];
          mt[d][k] = mt[d][k-1];
        end
        mv[d][0] = i_mul_valid;
        mp[d][0] = ref_mul(wid[d], a_r[d], b_r[d], i_mul_signed);
        mt[d][0] = i_mul_tag;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int guard;
    i_rst_n     = 1'b0;
    i_flush     = 1'b0;
    i_mul_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    model_clear();
    @(negedge i_clk);

    // Reset held with valid inputs: nothing may come out.
    repeat (4) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom));
      cyc();
    end
    i_rst_n = 1'b1;
    idle(2);

    // Unsigned directed cases, including the all-ones extreme.
    drive(1'b1, 32'hFFFF, 32'hFFFF, 1'b0, 4'd3); cyc();
    drive(1'b1, 32'h1234, 32'h0010, 1'b0, 4'd5); cyc();
    idle(8);

    // Signed and unsigned issued back to back.
    drive(1'b1, 32'h8000, 32'h8000, 1'b1, 4'd1); cyc();
    drive(1'b1, 32'hFFFF, 32'h0002, 1'b1, 4'd2); cyc();
    drive(1'b1, 32'hFFFF, 32'h0002, 1'b0, 4'd4); cyc();
    idle(8);

    // Backpressure: 20 accepted random ops while ready toggles at random.
    n_acc = 0;
    guard = 0;
    while (n_acc < 20 && guard < 400) begin
      i_mul_ready = 1'($urandom_range(0, 1));
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom));
      if (!(mv[0][lat[0]-1] && !i_mul_ready)) n_acc++;
      cyc();
      guard++;
    end
    i_mul_ready = 1'b1;
    idle(10);

    // Flush with 4 ops in flight and a valid input in the same cycle.
    repeat (4) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom));
      cyc();
    end
    i_flush = 1'b1;
    drive(1'b1, 32'h00AA, 32'h0055, 1'b0, 4'd9); cyc();
    i_flush = 1'b0;
    idle(8);
    drive(1'b1, 32'h7FFF, 32'h8000, 1'b1, 4'd6); cyc();
    idle(8);

    // Random mix: corner operands, random ready, occasional flush.
    repeat (150) begin
      logic [31:0] a;
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0:       a = 32'h8000;
        1:       a = 32'hFFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'h8000 : $urandom;
      i_mul_ready = ($urandom_range(0, 3) != 0);
      i_flush     = ($urandom_range(0, 29) == 0);
      drive(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)), 4'($urandom));
      cyc();
    end
    i_flush     = 1'b0;
    i_mul_ready = 1'b1;
    idle(10);

    // Reset asserted with products in flight drops all of them.
    repeat (3) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 4'($urandom));
      cyc();
    end
    i_rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0); cyc();
    i_rst_n = 1'b1;
    idle(9);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
